// File: rtl/cfg_ser_pkg.sv
// cfg_ser_pkg: shared constants for the config chain serializer.
// Register offsets, CTRL/STATUS bit positions, FSM states, CRC step.
package cfg_ser_pkg;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_DATA   = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;
    localparam logic [1:0] OFF_CRC    = 2'd3;

    localparam int CTRL_GO   = 15;

    localparam int STAT_BUSY = 0;
    localparam int STAT_LVL  = 1;
    localparam int STAT_OVF  = 4;
    localparam int STAT_CERR = 5;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        LOAD,
        SHIFT,
        SET
    } state_t;

    // One serial bit of CRC-16-CCITT, MSB-first, no reflection.
    function automatic logic [15:0] crc16_step(
        input logic [15:0] c,
        input logic        b
    );
        return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/cfg_word_fifo.sv
// cfg_word_fifo: synchronous word FIFO with occupancy count.
// A push into a full FIFO is taken only when a pop happens the same cycle.
module cfg_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [AW:0]      cnt;
    logic             pop_en;
    logic             push_en;

    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign level   = cnt;
    assign dout    = mem[rp];
    assign pop_en  = pop & ~empty;
    assign push_en = push & (~full | pop_en);

    // Storage array, written on accepted pushes.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wp] <= din;
        end
    end

    // Pointers and occupancy; reset flushes the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push_en) begin
                wp <= wp + 1'b1;
            end
            if (pop_en) begin
                rp <= rp + 1'b1;
            end
            unique case ({push_en, pop_en})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/config_chain_serializer.sv
// config_chain_serializer: Wishbone slave that streams buffered config
// words LSB-first onto one column chain. Optional CRC: CFG_CRC_EN.
module config_chain_serializer
    import cfg_ser_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          NUM_COLS   = 4,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_data_i,
    input  logic [31:0]         wbs_addr_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_data_o,
    output logic                cen,
    output logic [NUM_COLS-1:0] shift_out,
    output logic [NUM_COLS-1:0] set_out
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    state_t        state;
    state_t        state_nx;
    logic [1:0]    col;
    logic [15:0]   frame_bits;
    logic [15:0]   bit_cnt;
    logic [4:0]    word_cnt;
    logic [31:0]   shreg;
    logic          ovf;
    logic          ctrl_err;
    logic [15:0]   crc;
    logic [31:0]   rdata;

    logic          hit;
    logic          req;
    logic          wr;
    logic          rd;
    logic [1:0]    off;
    logic          busy;
    logic          ctrl_wr;
    logic          col_bad;
    logic          go_bad;
    logic          ctrl_ok;
    logic          go;
    logic          push_req;
    logic          pop;
    logic [31:0]   fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [LW-1:0] fifo_level;
    logic          unused;

    assign unused = ^{wbs_sel_i, wbs_addr_i[1:0]};

    assign hit = wbs_stb_i & wbs_cyc_i
               & (wbs_addr_i[31:4] == BASE_ADDR[31:4]);
    assign req = hit & ~wbs_ack_o;
    assign off = wbs_addr_i[3:2];
    assign wr  = req & wbs_we_i;
    assign rd  = req & ~wbs_we_i;

    assign busy     = (state != IDLE);
    assign ctrl_wr  = wr & (off == OFF_CTRL);
    assign col_bad  = 32'(wbs_data_i[1:0]) >= 32'(NUM_COLS);
    assign go_bad   = wbs_data_i[CTRL_GO] & (wbs_data_i[31:16] == 16'd0);
    assign ctrl_ok  = ctrl_wr & ~busy & ~col_bad & ~go_bad;
    assign go       = ctrl_ok & wbs_data_i[CTRL_GO];
    assign push_req = wr & (off == OFF_DATA);

    cfg_word_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (push_req),
        .din   (wbs_data_i),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Register read mux; DATA is write-only and reads as zero.
    always_comb begin
        rdata = '0;
        unique case (off)
            OFF_CTRL: rdata = {frame_bits, 14'd0, col};
            OFF_STATUS: begin
                rdata[STAT_BUSY]     = busy;
                rdata[STAT_LVL +: 3] = 3'(fifo_level);
                rdata[STAT_OVF]      = ovf;
                rdata[STAT_CERR]     = ctrl_err;
            end
            OFF_CRC:  rdata = {16'd0, crc};
            default:  rdata = '0;
        endcase
    end

    // Frame FSM next state and chain-side outputs.
    always_comb begin
        state_nx  = state;
        cen       = 1'b0;
        shift_out = '0;
        set_out   = '0;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (go) begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (!fifo_empty) begin
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                pop      = 1'b1;
                state_nx = SHIFT;
            end
            SHIFT: begin
                cen       = 1'b1;
                shift_out = NUM_COLS'(shreg[0]) << col;
                if (bit_cnt + 16'd1 == frame_bits) begin
                    state_nx = SET;
                end else if (word_cnt == 5'd31) begin
                    state_nx = fifo_empty ? WAIT : LOAD;
                end
            end
            SET: begin
                set_out  = NUM_COLS'(1'b1) << col;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Bus handshake, registers, sticky flags and the shift datapath.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            wbs_ack_o  <= 1'b0;
            wbs_data_o <= '0;
            col        <= '0;
            frame_bits <= '0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            shreg      <= '0;
            ovf        <= 1'b0;
            ctrl_err   <= 1'b0;
        end else begin
            state      <= state_nx;
            wbs_ack_o  <= req;
            wbs_data_o <= rd ? rdata : '0;
            if (ctrl_ok) begin
                col        <= wbs_data_i[1:0];
                frame_bits <= wbs_data_i[31:16];
            end
            if (ctrl_wr && !ctrl_ok) begin
                ctrl_err <= 1'b1;
            end
            if (push_req && fifo_full && !pop) begin
                ovf <= 1'b1;
            end
            if (wr && off == OFF_STATUS) begin
                ovf      <= 1'b0;
                ctrl_err <= 1'b0;
            end
            if (go) begin
                bit_cnt <= '0;
            end
            if (state == LOAD) begin
                shreg    <= fifo_dout;
                word_cnt <= '0;
            end else if (state == SHIFT) begin
                shreg    <= shreg >> 1;
                bit_cnt  <= bit_cnt + 16'd1;
                word_cnt <= word_cnt + 5'd1;
            end
        end
    end

`ifdef CFG_CRC_EN
    // Running CRC over every bit placed on the chain.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || go) begin
            crc <= CRC_INIT;
        end else if (state == SHIFT) begin
            crc <= crc16_step(crc, shreg[0]);
        end
    end
`else
    assign crc = 16'h0000;
`endif

endmodule
